rr_arbiter_dec8: RTL and testbench
==================================

Name: rr_arbiter_dec8

Overview:
- 8-requester round-robin arbiter that shares one resource among requesters; the one-hot grant is produced by an enabled 3-to-8 decoder driven by the registered winner index.
- Sits between eight request sources and a shared resource (bus, port, register bank).
- Adds a per-grant hold limit so one requester cannot starve the others.
- Global enable `en` mirrors decoder-enable semantics: `en`=0 forces all grants to zero.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8 to match the 3-to-8 decode, elaborate-time error otherwise.
- IDX_W, 3, width of the winner index.
- MAX_HOLD, 16, maximum cycles a single grant stays asserted (legal range 2..31).
- HOLD_W, 5, width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  arbiter enable; 0 = no grants.
- req  input  8  request vector; req[i] held high while requester i wants the resource.
- done  input  1  the current owner releases the resource this cycle.
- gnt  output  8  one-hot grant; all zero when no grant is active.
- gnt_idx  output  3  index of the current or last owner (registered).
- gnt_valid  output  1  a grant is active (registered).
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- FSM states are IDLE and BUSY. Reset enters IDLE.
- Reset values: gnt=0, gnt_idx=3'd7, gnt_valid=0, timeout=0, hold counter=0, last pointer=7. With last pointer at 7, req[0] has first priority after reset.
- IDLE:
  - If en=1 and req≠0, select the first set req[i] searching from last+1 upward, wrapping 7→0.
  - At that clock edge: gnt_idx<=i, gnt_valid<=1, last<=i, hold counter<=0, go to BUSY.
  - Otherwise stay in IDLE with gnt_valid=0.
- Latency: req sampled at edge k gives gnt visible after edge k (one cycle).
- gnt = decode(gnt_idx) with decoder enable = gnt_valid. gnt is purely a function of registered state and is glitch-free relative to req.
- BUSY: the hold counter increments each cycle. Release happens at the next edge (gnt_valid<=0, go to IDLE) when any of these holds:
  - done=1;
  - req[gnt_idx]=0;
  - en=0;
  - hold counter = MAX_HOLD-1, which also sets timeout<=1 for exactly one cycle.
- Simultaneous release conditions: done, request drop or en=0 take precedence over the hold limit, and timeout is not pulsed.
- There is always exactly one IDLE cycle between consecutive grants. Grants never overlap and never go back-to-back.
- A lone requester that keeps requesting after a timeout is re-granted after the one IDLE gap; round-robin is trivially satisfied.
- Requests arriving during BUSY are ignored until the next IDLE cycle. req changes on other lines during BUSY have no effect.
- en=0 in IDLE: no grant, pointer unchanged.
- Reset mid-grant: gnt drops to zero asynchronously, the FSM returns to IDLE, and the pointer returns to 7.
- Invariant: $onehot0(gnt) in every cycle. gnt≠0 implies gnt_valid=1.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: the pointer is ignored and the lowest set req index always wins (fixed priority). The hold limit and timeout remain active.
- Undefined (default): round-robin as specified above.

Decomposition:
- Package arb_pkg holds:
  - localparams N_REQ=8 and IDX_W=3;
  - typedef enum state_t {IDLE, BUSY};
  - a function next_rr(req, last) returning the winner index.
- One sub-module, arb_dec3to8_en: an enabled 3-to-8 one-hot decoder (inputs en, idx[2:0]; output y[7:0]), instantiated once to form gnt.

Test Plan:
- Reset then idle: rst_n low for 3 cycles with req=8'hFF → gnt=0, gnt_valid=0, gnt_idx=7. Release reset with en=1 → the first grant is gnt=8'h01 one cycle later.
- Round-robin rotation: req=8'hFF held, done pulsed one cycle after each grant → gnt sequence 01,02,04,…,80,01, with one IDLE cycle between grants.
- Hold limit: req=8'h04 held, done=0 → gnt=8'h04 for exactly 16 cycles, timeout=1 for one cycle, one cycle of gnt=0, then gnt=8'h04 again.
- Enable gating: during gnt=8'h10, drive en=0 → gnt=0 at the next edge with no timeout. Hold en=0 for 5 cycles with req=8'hFF → gnt stays 0.
- Simultaneous events: done=1 on the same cycle the hold counter reaches 15 → release with timeout=0. A req[gnt_idx] drop releases at the next edge.
- Reset mid-grant, plus ARB_FIXED_PRIO_EN: assert rst_n=0 while gnt=8'h20 → gnt=0 immediately. Separately, with the macro defined and req=8'h0A, repeated grants are always 8'h02.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the 8-way arbiter.
// Defines the requester count, the index width, the FSM state type and the
// winner-selection functions.
package arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Returns the first set request after 'last', wrapping 7 -> 0.
    // When req is all zero the result is 'last'; callers gate on |req.
    function automatic logic [IDX_W-1:0] next_rr(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] win;
        logic [IDX_W-1:0] cand;
        logic             found;
        win   = last;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = last + IDX_W'(k);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    // Returns the lowest set request index (fixed priority).
    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_REQ-1:0] req);
        logic [IDX_W-1:0] win;
        win = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                win = IDX_W'(k);
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/arb_dec3to8_en.sv
// Enabled 3-to-8 one-hot decoder: y has the bit at idx set only when en is high.
module arb_dec3to8_en
    import arb_pkg::*;
(
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    output logic [N_REQ-1:0] y
);

    // One-hot decode, all zeros when disabled.
    always_comb begin
        y = '0;
        if (en) begin
            y[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter_dec8.sv
// 8-requester round-robin arbiter with a per-grant hold limit.
// The grant is the enabled decode of the registered winner index, so it only
// changes on clock edges (or asynchronously on reset) and never follows req.
// Build option: define ARB_FIXED_PRIO_EN to replace round-robin with fixed
// priority (lowest set request wins); the hold limit still applies.
module rr_arbiter_dec8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned HOLD_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    // Reject configurations the decoder and hold counter cannot support.
    if (N_REQ != 8) begin : g_bad_nreq
        $error("rr_arbiter_dec8: N_REQ must be 8");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 31) begin : g_bad_hold
        $error("rr_arbiter_dec8: MAX_HOLD must be in 2..31");
    end
    if ((1 << HOLD_W) <= MAX_HOLD) begin : g_bad_hold_w
        $error("rr_arbiter_dec8: HOLD_W too narrow for MAX_HOLD");
    end

    state_t             state_q, state_d;
    // The winner index doubles as the round-robin pointer ("last owner").
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               timeout_q, timeout_d;
    logic [IDX_W-1:0]   winner;
    logic               release_req;

`ifdef ARB_FIXED_PRIO_EN
    assign winner = lowest_set(req);
`else
    assign winner = next_rr(req, idx_q);
`endif

    // Owner-driven release conditions; these beat the hold limit.
    assign release_req = done || !req[idx_q] || !en;

    // Next-state logic for the grant FSM, hold counter and timeout pulse.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en && (|req)) begin
                    idx_d   = winner;
                    hold_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                hold_d = hold_q + HOLD_W'(1);
                if (release_req) begin
                    state_d = IDLE;
                end else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset points the pointer at 7 so req[0] wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= IDX_W'(N_REQ - 1);
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt_valid = (state_q == BUSY);
    assign gnt_idx   = idx_q;
    assign timeout   = timeout_q;

    arb_dec3to8_en u_dec (
        .en  (gnt_valid),
        .idx (idx_q),
        .y   (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter_dec8.sv
// Directed self-checking bench for rr_arbiter_dec8.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_rr_arbiter_dec8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    rr_arbiter_dec8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Structural invariants, checked every cycle away from the active edge.
    always @(negedge clk) begin
        check("onehot0", 32'($onehot0(gnt)), 32'd1);
        check("gnt_implies_valid", 32'((gnt == 8'h00) || gnt_valid), 32'd1);
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        req   = 8'hFF;
        done  = 1'b0;
        repeat (3) tick();
        check("rst_gnt", 32'(gnt), 32'h00);
        check("rst_valid", 32'(gnt_valid), 32'd0);
        check("rst_idx", 32'(gnt_idx), 32'd7);
        check("rst_timeout", 32'(timeout), 32'd0);

        rst_n = 1'b1;
        tick();
        check("first_gnt", 32'(gnt), 32'h01);
        check("first_idx", 32'(gnt_idx), 32'd0);

`ifdef ARB_FIXED_PRIO_EN
        // Fixed priority: with req 0A the lowest index (1) always wins.
        req = 8'h0A;
        for (int k = 0; k < 4; k++) begin
            done = 1'b1;
            tick();
            check("fp_gap", 32'(gnt), 32'h00);
            done = 1'b0;
            tick();
            check("fp_gnt", 32'(gnt), 32'h02);
        end
`else
        // Rotation: done in each grant's first cycle, one idle cycle between.
        for (int k = 1; k <= 8; k++) begin
            done = 1'b1;
            tick();
            check("rot_gap", 32'(gnt), 32'h00);
            done = 1'b0;
            tick();
            check("rot_gnt", 32'(gnt), 32'(8'h01 << (k % 8)));
        end

        // Owner 0 drops its request: released at the next edge, no timeout.
        req = 8'h04;
        tick();
        check("drop_gnt", 32'(gnt), 32'h00);
        check("drop_timeout", 32'(timeout), 32'd0);

        // Hold limit: 16 cycles of grant, timeout pulse, one gap, re-grant.
        tick();
        check("hold_gnt_0", 32'(gnt), 32'h04);
        for (int c = 1; c < 16; c++) begin
            tick();
            check("hold_gnt", 32'(gnt), 32'h04);
            check("hold_no_to", 32'(timeout), 32'd0);
        end
        tick();
        check("to_gnt", 32'(gnt), 32'h00);
        check("to_pulse", 32'(timeout), 32'd1);
        check("to_valid", 32'(gnt_valid), 32'd0);
        tick();
        check("to_regrant", 32'(gnt), 32'h04);
        check("to_pulse_end", 32'(timeout), 32'd0);

        // done on the cycle the hold counter reaches 15: release, no timeout.
        repeat (15) tick();
        check("sim_gnt_15", 32'(gnt), 32'h04);
        done = 1'b1;
        tick();
        check("sim_gnt", 32'(gnt), 32'h00);
        check("sim_timeout", 32'(timeout), 32'd0);
        done = 1'b0;
        tick();
        check("sim_regrant", 32'(gnt), 32'h04);

        // Move the grant to requester 4, then gate with en.
        req = 8'h10;
        tick();
        check("en_pre_gap", 32'(gnt), 32'h00);
        tick();
        check("en_pre_gnt", 32'(gnt), 32'h10);
        en = 1'b0;
        tick();
        check("en_off_gnt", 32'(gnt), 32'h00);
        check("en_off_timeout", 32'(timeout), 32'd0);
        req = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("en_off_hold", 32'(gnt), 32'h00);
        end
        // Pointer left at 4 while disabled, so 5 wins next.
        en = 1'b1;
        tick();
        check("en_on_gnt", 32'(gnt), 32'h20);
        check("en_on_idx", 32'(gnt_idx), 32'd5);

        // Reset mid-grant clears the grant without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_gnt", 32'(gnt), 32'h00);
        check("async_rst_idx", 32'(gnt_idx), 32'd7);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_gnt", 32'(gnt), 32'h01);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
